// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// The PC register has no enable, so "hold" is a forward branch by HOLD_TARGET.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_FETCH = 3'd2,
      S_EXEC  = 3'd3,
      S_HALT  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   localparam int          PCW         = 8;
   localparam int          IW_DEFAULT  = 16;
   localparam logic [7:0]  HOLD_TARGET = 8'd0;

endpackage

// File: rtl/pc_seq_timeout.sv
// Saturating fetch-wait counter; expired is high on the LIMIT-th enabled cycle,
// so the caller can still let a same-cycle acknowledge take priority.
module pc_seq_timeout #(
   parameter int LIMIT = 15
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != CNT_W'(LIMIT))) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // cnt counts completed wait cycles, so LIMIT-1 means this is the last allowed one
   assign expired = en && (cnt >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving an external 8-bit PC register through its
// start / forward-branch / backward-branch / increment update modes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, PC held, waiting for go_i
// S_START | one cycle, loads PC with startadd_i
// S_FETCH | request imem at pc_i, PC held, wait for ack (bounded)
// S_EXEC  | one cycle, instruction valid, PC advanced per decode
// S_HALT  | halt decoded, PC held on the halt instruction, wait for go_i
// S_ERR   | fetch timed out, PC held, wait for go_i
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int IW          = IW_DEFAULT,
   parameter int ACK_TIMEOUT = 15,
   parameter int CW          = 16
) (
   input  logic            clock_i,
   input  logic            reset_i,
   input  logic            go_i,
   input  logic [PCW-1:0]  startadd_i,
   input  logic [PCW-1:0]  pc_i,
   output logic            imem_req_o,
   output logic [PCW-1:0]  imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [IW-1:0]   imem_data_i,
   output logic [IW-1:0]   instr_o,
   output logic            instr_valid_o,
   input  logic            br_taken_i,
   input  logic            br_back_i,
   input  logic [PCW-1:0]  br_off_i,
   input  logic            halt_i,
   output logic            pc_start_o,
   output logic [PCW-1:0]  pc_startadd_o,
   output logic            pc_branchf_o,
   output logic            pc_branchb_o,
   output logic [PCW-1:0]  pc_target_o,
   output logic            busy_o,
   output logic            err_o,
   output logic [CW-1:0]   retired_o
);

   state_t state;
   logic   to_clr;
   logic   to_en;
   logic   to_expired;

   assign to_en  = (state == S_FETCH);
   assign to_clr = (state != S_FETCH) || imem_ack_i;

   pc_seq_timeout #(
      .LIMIT (ACK_TIMEOUT)
   ) u_timeout (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .clr     (to_clr),
      .en      (to_en),
      .expired (to_expired)
   );

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state     <= S_IDLE;
         instr_o   <= '0;
         retired_o <= '0;
      end else begin
         case (state)
            S_IDLE, S_HALT, S_ERR: begin
               if (go_i) state <= S_START;
            end
            S_START: begin
               state <= S_FETCH;
            end
            S_FETCH: begin
               // an ack on the expiry cycle still completes the fetch
               if (imem_ack_i) begin
                  instr_o <= imem_data_i;
                  state   <= S_EXEC;
               end else if (to_expired) begin
                  state <= S_ERR;
               end
            end
            S_EXEC: begin
               retired_o <= retired_o + CW'(1);
               state     <= halt_i ? S_HALT : S_FETCH;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // PC controls are combinational; the PC register itself supplies the edge
   always_comb begin
      pc_start_o   = 1'b0;
      pc_branchf_o = 1'b1;
      pc_branchb_o = 1'b0;
      pc_target_o  = HOLD_TARGET;
      case (state)
         S_START: begin
            pc_start_o   = 1'b1;
            pc_branchf_o = 1'b0;
         end
         S_EXEC: begin
            if (!halt_i) begin
               pc_branchf_o = br_taken_i & ~br_back_i;
               pc_branchb_o = br_taken_i & br_back_i;
               pc_target_o  = br_taken_i ? br_off_i : HOLD_TARGET;
            end
         end
         default: begin
         end
      endcase
   end

   assign pc_startadd_o = startadd_i;
   assign imem_addr_o   = pc_i;
   assign imem_req_o    = (state == S_FETCH);
   assign instr_valid_o = (state == S_EXEC);
   assign busy_o        = (state == S_START) || (state == S_FETCH) || (state == S_EXEC);
   assign err_o         = (state == S_ERR);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: stimulus queues the expected EXEC-cycle view of each
// instruction, a negedge monitor pops and compares whenever instr_valid_o is high.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        go;
   logic [7:0]  startadd;
   logic [7:0]  pc = 8'h00;
   logic        ack;
   logic [15:0] data;
   logic        taken, back, halt;
   logic [7:0]  off;

   logic        req, ivalid, pstart, bf, bb, busy, err;
   logic [7:0]  addr, sadd, tgt;
   logic [15:0] instr, retired;

   logic        req4, ivalid4, pstart4, bf4, bb4, busy4, err4;
   logic [7:0]  addr4, sadd4, tgt4;
   logic [15:0] instr4;
   logic [3:0]  retired4;

   always #5 clk = ~clk;

   pc_sequencer #(.IW(16), .ACK_TIMEOUT(15), .CW(16)) u_dut (
      .clock_i(clk), .reset_i(rst), .go_i(go), .startadd_i(startadd), .pc_i(pc),
      .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
      .instr_o(instr), .instr_valid_o(ivalid), .br_taken_i(taken), .br_back_i(back),
      .br_off_i(off), .halt_i(halt), .pc_start_o(pstart), .pc_startadd_o(sadd),
      .pc_branchf_o(bf), .pc_branchb_o(bb), .pc_target_o(tgt), .busy_o(busy),
      .err_o(err), .retired_o(retired));

   pc_sequencer #(.IW(16), .ACK_TIMEOUT(15), .CW(4)) u_dut4 (
      .clock_i(clk), .reset_i(rst), .go_i(go), .startadd_i(startadd), .pc_i(pc),
      .imem_req_o(req4), .imem_addr_o(addr4), .imem_ack_i(ack), .imem_data_i(data),
      .instr_o(instr4), .instr_valid_o(ivalid4), .br_taken_i(taken), .br_back_i(back),
      .br_off_i(off), .halt_i(halt), .pc_start_o(pstart4), .pc_startadd_o(sadd4),
      .pc_branchf_o(bf4), .pc_branchb_o(bb4), .pc_target_o(tgt4), .busy_o(busy4),
      .err_o(err4), .retired_o(retired4));

   // external PC register, wraps modulo 256
   always @(posedge clk) begin
      if (pstart)   pc <= sadd;
      else if (bf)  pc <= pc + tgt;
      else if (bb)  pc <= pc - tgt;
      else          pc <= pc + 8'd1;
   end

   typedef struct {
      logic [15:0] instr;
      logic [7:0]  pc;
      logic [15:0] ret;
      logic        bf;
      logic        bb;
      logic [7:0]  tgt;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   n_ret = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req_v, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("ctrl_onehot", 32'($countones({pstart, bf, bb}) <= 1), 32'd1);
         if (ivalid) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_exec actual=instr %h required=none", instr);
            end else begin
               mon_e = sb.pop_front();
               chk("exec_instr", instr, mon_e.instr);
               chk("exec_pc", pc, mon_e.pc);
               chk("exec_retired", retired, mon_e.ret);
               chk("exec_retired4", retired4, mon_e.ret[3:0]);
               chk("exec_bf", bf, mon_e.bf);
               chk("exec_bb", bb, mon_e.bb);
               chk("exec_target", tgt, mon_e.tgt);
            end
         end
      end
   end

   task automatic check_hold(input string name);
      chk({name, "_bf"}, bf, 1'b1);
      chk({name, "_bb"}, bb, 1'b0);
      chk({name, "_start"}, pstart, 1'b0);
      chk({name, "_target"}, tgt, 8'h00);
   endtask

   // called at a negedge in IDLE/HALT/ERR; returns at the first FETCH negedge
   task automatic go_start(input logic [7:0] sa);
      go = 1'b1;
      startadd = sa;
      @(negedge clk);
      chk("start_pulse", pstart, 1'b1);
      chk("start_busy", busy, 1'b1);
      chk("start_err", err, 1'b0);
      chk("start_bf", bf, 1'b0);
      go = 1'b0;
      @(negedge clk);
      chk("start_once", pstart, 1'b0);
      chk("start_pc", pc, sa);
      chk("start_req", req, 1'b1);
   endtask

   // called at the first FETCH negedge; returns at the negedge after EXEC
   task automatic run_instr(input int dly, input logic tk, input logic bk,
                            input logic [7:0] of, input logic hl, input logic [7:0] epc);
      exp_t e;
      e.instr = {epc, ~epc};
      e.pc    = epc;
      e.ret   = 16'(n_ret);
      e.bf    = hl | (tk & ~bk);
      e.bb    = ~hl & tk & bk;
      e.tgt   = (hl | ~tk) ? 8'h00 : of;
      sb.push_back(e);
      n_ret++;
      for (int i = 0; i < dly; i++) begin
         chk("fetch_pc", pc, epc);
         chk("fetch_addr", addr, epc);
         chk("fetch_req", req, 1'b1);
         chk("fetch_err", err, 1'b0);
         check_hold("fetch_hold");
         @(negedge clk);
      end
      data  = {epc, ~epc};
      ack   = 1'b1;
      taken = tk;
      back  = bk;
      off   = of;
      halt  = hl;
      @(negedge clk);
      ack  = 1'b0;
      data = 16'hDEAD;
      @(negedge clk);
      taken = 1'b0;
      back  = 1'b0;
      off   = 8'h00;
      halt  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; go = 1'b0; startadd = 8'h00; ack = 1'b0; data = 16'h0000;
      taken = 1'b0; back = 1'b0; off = 8'h00; halt = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req", req, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_retired", retired, 16'h0000);
      chk("rst_valid", ivalid, 1'b0);
      check_hold("rst_hold");
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 1'b0);

      // sequential run from 0x10 with zero-wait memory
      go_start(8'h10);
      run_instr(0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h10);
      run_instr(0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h11);
      run_instr(0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h12);
      chk("seq_retired3", retired, 16'd3);
      chk("seq_pc13", pc, 8'h13);

      // 3-cycle ack delay, then branches and halt
      run_instr(3, 1'b1, 1'b0, 8'h0D, 1'b0, 8'h13);
      run_instr(0, 1'b1, 1'b0, 8'h05, 1'b0, 8'h20);
      run_instr(0, 1'b1, 1'b1, 8'h30, 1'b0, 8'h25);
      run_instr(1, 1'b1, 1'b0, 8'h00, 1'b0, 8'hF5);
      run_instr(0, 1'b1, 1'b1, 8'h07, 1'b1, 8'hF5);
      chk("halt_busy", busy, 1'b0);
      chk("halt_req", req, 1'b0);
      chk("halt_pc", pc, 8'hF5);
      check_hold("halt_hold");
      @(negedge clk);
      chk("halt_pc_held", pc, 8'hF5);
      chk("halt_retired", retired, 16'd8);

      // ack on the 15th FETCH cycle still completes
      go_start(8'h40);
      run_instr(14, 1'b0, 1'b0, 8'h00, 1'b0, 8'h40);

      // no ack for 15 FETCH cycles -> ERR
      for (int i = 0; i < 15; i++) begin
         chk("to_req", req, 1'b1);
         chk("to_err_early", err, 1'b0);
         @(negedge clk);
      end
      chk("to_err", err, 1'b1);
      chk("to_req_off", req, 1'b0);
      chk("to_busy", busy, 1'b0);
      chk("to_pc", pc, 8'h41);
      check_hold("err_hold");
      @(negedge clk);
      chk("err_stays", err, 1'b1);
      go_start(8'h80);

      // asynchronous reset between edges in FETCH
      #2 rst = 1'b1;
      #1;
      chk("arst_req", req, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_err", err, 1'b0);
      chk("arst_instr", instr, 16'h0000);
      chk("arst_retired", retired, 16'h0000);
      chk("arst_retired4", retired4, 4'h0);
      check_hold("arst_hold");
      @(negedge clk);
      rst = 1'b0;
      n_ret = 0;
      @(negedge clk);

      // 17 instructions: 4-bit counter wraps to 1
      go_start(8'h00);
      for (int i = 0; i < 17; i++) begin
         run_instr(0, 1'b0, 1'b0, 8'h00, 1'b0, 8'(i));
      end
      chk("wrap_retired16", retired, 16'd17);
      chk("wrap_retired4", retired4, 4'h1);
      chk("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
